// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types: queue entry and instruction bus request/response.
package pipes;

  localparam int unsigned INSTR_BYTES = 4;

  // One fetched instruction and the address it came from.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction bus request: held valid with a stable address until data_ok.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  // Instruction bus response: data valid for the outstanding request when data_ok.
  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  // Instructions are word aligned; the low address bits carry no meaning.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular storage for fetched instructions: power-of-two depth, wrapping
// pointers, explicit occupancy counter, single-cycle clear.
module fetch_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = pipes::fetch_entry_t,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          clear,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Clear wins over everything; a push into a full queue is only legal alongside a pop.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one request at a time on the instruction
// bus, queues returned instructions in order, and flushes on redirect.
module fetch_queue
  import pipes::*;
#(
  parameter int unsigned  DEPTH    = 4,
  parameter logic [63:0]  RESET_PC = 64'h8000_0000,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  output ibus_req_t     ireq,
  input  ibus_resp_t    iresp,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [CW-1:0] count
);

  // DISCARD: a request is still on the bus but its answer belongs to a
  // pre-redirect path and must be thrown away.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t       state;
  logic [63:0]  fetch_pc;   // next address to fetch on the current path
  logic [63:0]  req_addr;   // address of the request currently on the bus
  logic         full;
  logic         empty;
  logic         issue;
  logic         accept;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  // New request only from IDLE, with room in the queue and no redirect pending.
  assign issue  = (state == IDLE) && !full && !redirect_valid;
  assign accept = (state == WAIT) && iresp.data_ok && !redirect_valid;
  assign pop    = out_valid && out_ready && !redirect_valid;

  assign push_entry = '{pc: req_addr, instr: iresp.data};

  // Bus request: address comes from fetch_pc while issuing, then is held
  // from req_addr so later redirects cannot disturb an in-flight request.
  always_comb begin
    ireq       = '0;
    ireq.valid = !reset && (issue || (state != IDLE));
    ireq.addr  = (state == IDLE) ? fetch_pc : req_addr;
  end

  // Fetch control: one outstanding request, redirect always reloads fetch_pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
          end else if (!full) begin
            state    <= WAIT;
            req_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (iresp.data_ok) begin
            state <= IDLE;
            if (redirect_valid) fetch_pc <= align_pc(redirect_pc);
            else                fetch_pc <= req_addr + 64'(INSTR_BYTES);
          end else if (redirect_valid) begin
            state    <= DISCARD;
            fetch_pc <= align_pc(redirect_pc);
          end
        end
        DISCARD: begin
          if (iresp.data_ok) state <= IDLE;
          if (redirect_valid) fetch_pc <= align_pc(redirect_pc);
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect_valid),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a request-level model of the bus and the
// queue predicts requests and queue contents; a negedge monitor compares.
module tb_fetch_queue;
  import pipes::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int unsigned CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  ibus_req_t     ireq;
  ibus_resp_t    iresp;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_pc;
  logic [31:0]   out_instr;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .count          (count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: expected queue contents, the one outstanding bus request,
  // the next fetch address on the current path, and a log of issued addresses.
  fetch_entry_t exp_q[$];
  logic [63:0]  req_log[$];
  bit           pend    = 0;
  bit           killed  = 0;
  logic [63:0]  paddr   = '0;
  logic [31:0]  pdata   = '0;
  logic [63:0]  mpc     = RESET_PC;
  int           age     = 0;
  int           lat     = 0;
  bit           issue_now = 0;

  // Stimulus knobs.
  int lat_mode  = 0;   // <0: random latency 0..3, else fixed
  int rdy_mode  = 0;   // 0: rdy_val, 1: random, 2: follow data_ok
  bit rdy_val   = 1;
  int redir_pct = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model update at each clock edge (or reset).
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      exp_q.delete();
      pend = 0;
      mpc  = RESET_PC;
    end else begin
      if (pend) begin
        if (iresp.data_ok) begin
          if (!redirect_valid && !killed) begin
            exp_q.push_back('{pc: paddr, instr: pdata});
            mpc = paddr + 64'd4;
          end
          pend = 0;
        end else begin
          age++;
          if (redirect_valid) killed = 1;
        end
      end else if (issue_now) begin
        pend   = 1;
        paddr  = mpc;
        pdata  = $urandom;
        killed = 0;
        age    = 0;
        lat    = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        req_log.push_back(mpc);
      end
      if (redirect_valid) begin
        exp_q.delete();
        mpc = redirect_pc & ~64'd3;
      end
    end
  end

  // Monitor: compare DUT outputs with the model mid-cycle, consume accepted heads.
  initial begin : mon
    bit exp_v;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_ireq_valid", ireq.valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        issue_now = 0;
      end else begin
        exp_v = pend || ((exp_q.size() < DEPTH) && !redirect_valid);
        chk("count", count, exp_q.size());
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("out_pc", out_pc, exp_q[0].pc);
          chk("out_instr", out_instr, exp_q[0].instr);
        end
        chk("ireq_valid", ireq.valid, exp_v);
        if (exp_v) chk("ireq_addr", ireq.addr, pend ? paddr : mpc);
        issue_now = !pend && exp_v;
        if (exp_q.size() != 0 && out_ready && !redirect_valid) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive();
    iresp.data_ok = pend && (age >= lat);
    iresp.data    = iresp.data_ok ? pdata : 32'hDEAD_BEEF;
    case (rdy_mode)
      0:       out_ready = rdy_val;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = iresp.data_ok;
    endcase
    redirect_valid = (redir_pct > 0) && (int'($urandom_range(0, 99)) < redir_pct);
    if (redirect_valid) begin
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF4 | 64'($urandom_range(0, 3));
      else                           redirect_pc = {$urandom, $urandom};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit hit;
    reset = 1; iresp = '0; redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    repeat (3) @(posedge clk);

    // Reset release, streaming fetch with one-cycle responses.
    req_log.delete();
    lat_mode = 0; rdy_mode = 0; rdy_val = 1;
    step(); reset = 0;
    at_neg();
    chk("p1_first_req", ireq.valid, 1);
    chk("p1_first_addr", ireq.addr, RESET_PC);
    repeat (12) step();
    chk("p1_req_count", req_log.size() >= 3, 1);
    if (req_log.size() >= 3)
      for (int i = 0; i < 3; i++) chk("p1_addr_seq", req_log[i], RESET_PC + 64'(4 * i));

    // Fill to full with no consumer; requests stop, one pop resumes them.
    rdy_val = 0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin step(); if (count == CW'(DEPTH)) hit = 1; end
    chk("p2_reached_full", count, DEPTH);
    for (int i = 0; i < 3; i++) begin
      step(); at_neg();
      chk("p2_no_req_full", ireq.valid, 0);
    end
    step(); out_ready = 1;
    at_neg();
    step(); at_neg();
    chk("p2_resume_req", ireq.valid, 1);

    // Redirect while a request is outstanding; its response is dropped.
    rdy_val = 1; lat_mode = 2;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin step(); if (pend && !iresp.data_ok) hit = 1; end
    chk("p3_found_wait", hit, 1);
    n = req_log.size();
    redirect_valid = 1; redirect_pc = 64'h8000_1000;
    step(); at_neg();
    chk("p3_flushed", count, 0);
    for (int i = 0; i < 20 && req_log.size() <= n; i++) step();
    chk("p3_next_logged", req_log.size() > n, 1);
    if (req_log.size() > n) chk("p3_next_addr", req_log[n], 64'h8000_1000);

    // Redirect coinciding with data_ok and a pop at count 2.
    rdy_val = 0; lat_mode = 1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin step(); if (count == 2 && iresp.data_ok) hit = 1; end
    chk("p4_setup", hit, 1);
    out_ready = 1; redirect_valid = 1; redirect_pc = 64'h8000_2002;
    step(); at_neg();
    chk("p4_count_zero", count, 0);
    chk("p4_out_valid", out_valid, 0);
    chk("p4_req_valid", ireq.valid, 1);
    chk("p4_req_addr", ireq.addr, 64'h8000_2000);

    // Steady simultaneous push and pop near full across pointer wrap.
    lat_mode = 0; rdy_mode = 0; rdy_val = 0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (count == CW'(DEPTH - 1)) begin hit = 1; rdy_mode = 2; out_ready = iresp.data_ok; end
    end
    chk("p5_setup", hit, 1);
    for (int i = 0; i < 16; i++) begin
      step(); at_neg();
      chk("p5_count_const", count, DEPTH - 1);
    end

    // Reset mid-request, stray data_ok right after release is ignored.
    rdy_mode = 0; rdy_val = 0; lat_mode = 3;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin step(); if (pend && !iresp.data_ok) hit = 1; end
    chk("p6_found_wait", hit, 1);
    reset = 1;
    step(); step();
    req_log.delete();
    reset = 0; iresp.data_ok = 1; iresp.data = 32'h1234_5678;
    at_neg();
    chk("p6_out_valid", out_valid, 0);
    chk("p6_req_addr", ireq.addr, RESET_PC);
    step(); at_neg();
    chk("p6_no_stray_push", out_valid, 0);
    chk("p6_log", req_log.size() >= 1, 1);
    if (req_log.size() >= 1) chk("p6_first_addr", req_log[0], RESET_PC);

    // Random traffic: latencies, back-pressure and redirects.
    lat_mode = -1; rdy_mode = 1; redir_pct = 6;
    repeat (1500) step();
    redir_pct = 0; rdy_mode = 0; rdy_val = 1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
